// File: rtl/rs_station_pkg.sv
// Shared widths, op encodings and default sizes for the ALU reservation station.
package rs_station_pkg;

  localparam int OPENUM_LEN = 6;
  localparam int DATA_LEN   = 32;
  localparam int ADDR_LEN   = 32;

  localparam logic [OPENUM_LEN-1:0] OPENUM_NOP  = 6'd0;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADD  = 6'd1;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADDI = 6'd2;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SUB  = 6'd3;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BEQ  = 6'd4;
  localparam logic [OPENUM_LEN-1:0] OPENUM_JAL  = 6'd5;

  localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_LEN-1:0] ZERO_ADDR = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int RS_SIZE_DEFAULT     = 16;
  localparam int RS_IDX_LEN_DEFAULT  = 4;
  localparam int ROB_IDX_LEN_DEFAULT = 4;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// ALU-path reservation station: buffers dispatched ops, snoops the ALU and LSB
// CDBs, issues the lowest-index ready entry each cycle. Optional perf counters
// are built when RS_PERF_CNT_EN is defined.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int RS_SIZE     = RS_SIZE_DEFAULT,
  parameter int RS_IDX_LEN  = RS_IDX_LEN_DEFAULT,
  parameter int ROB_IDX_LEN = ROB_IDX_LEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rollback,
  input  logic                   disp_valid,
  input  logic [OPENUM_LEN-1:0]  disp_openum,
  input  logic [DATA_LEN-1:0]    disp_V1,
  input  logic [DATA_LEN-1:0]    disp_V2,
  input  logic                   disp_Q1_rdy,
  input  logic                   disp_Q2_rdy,
  input  logic [ROB_IDX_LEN-1:0] disp_Q1,
  input  logic [ROB_IDX_LEN-1:0] disp_Q2,
  input  logic [DATA_LEN-1:0]    disp_imm,
  input  logic [ADDR_LEN-1:0]    disp_pc,
  input  logic [ROB_IDX_LEN-1:0] disp_rob_id,
  output logic                   rs_full,
  input  logic                   alu_cdb_valid,
  input  logic [ROB_IDX_LEN-1:0] alu_cdb_rob_id,
  input  logic [DATA_LEN-1:0]    alu_cdb_result,
  input  logic                   lsb_cdb_valid,
  input  logic [ROB_IDX_LEN-1:0] lsb_cdb_rob_id,
  input  logic [DATA_LEN-1:0]    lsb_cdb_result,
  output logic [OPENUM_LEN-1:0]  ex_openum,
  output logic [DATA_LEN-1:0]    ex_V1,
  output logic [DATA_LEN-1:0]    ex_V2,
  output logic [DATA_LEN-1:0]    ex_imm,
  output logic [ADDR_LEN-1:0]    ex_pc,
  output logic [ROB_IDX_LEN-1:0] ex_rob_id
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]            perf_issue_cnt,
  output logic [31:0]            perf_full_cnt
`endif
);

  typedef struct packed {
    logic                   busy;
    logic [OPENUM_LEN-1:0]  openum;
    logic [DATA_LEN-1:0]    v1;
    logic [DATA_LEN-1:0]    v2;
    logic                   q1_rdy;
    logic                   q2_rdy;
    logic [ROB_IDX_LEN-1:0] q1;
    logic [ROB_IDX_LEN-1:0] q2;
    logic [DATA_LEN-1:0]    imm;
    logic [ADDR_LEN-1:0]    pc;
    logic [ROB_IDX_LEN-1:0] rob_id;
  } entry_t;

  entry_t                ent_q   [RS_SIZE];
  entry_t                ent_snp [RS_SIZE];
  entry_t                disp_ent;
  logic [RS_SIZE-1:0]    busy_vec;
  logic [RS_SIZE-1:0]    ready_vec;
  logic                  free_found;
  logic [RS_IDX_LEN-1:0] free_idx;
  logic                  issue_found;
  logic [RS_IDX_LEN-1:0] issue_idx;

  // Returns {rdy, value}; ALU CDB wins when both buses carry the awaited tag.
  function automatic logic [DATA_LEN:0] wake(
    input logic                   rdy,
    input logic [DATA_LEN-1:0]    val,
    input logic [ROB_IDX_LEN-1:0] tag,
    input logic                   a_vld,
    input logic [ROB_IDX_LEN-1:0] a_tag,
    input logic [DATA_LEN-1:0]    a_res,
    input logic                   l_vld,
    input logic [ROB_IDX_LEN-1:0] l_tag,
    input logic [DATA_LEN-1:0]    l_res
  );
    if (rdy)                     return {1'b1, val};
    if (a_vld && (a_tag == tag)) return {1'b1, a_res};
    if (l_vld && (l_tag == tag)) return {1'b1, l_res};
    return {1'b0, val};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ent_q[i].q1_rdy & ent_q[i].q2_rdy;
    end
  end

  assign rs_full = ~free_found;

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_LEN)) u_free_sel (
    .req   (~busy_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_LEN)) u_ready_sel (
    .req   (ready_vec),
    .found (issue_found),
    .idx   (issue_idx)
  );

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_snp[i] = ent_q[i];
      if (ent_q[i].busy) begin
        {ent_snp[i].q1_rdy, ent_snp[i].v1} = wake(ent_q[i].q1_rdy, ent_q[i].v1, ent_q[i].q1,
          alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result);
        {ent_snp[i].q2_rdy, ent_snp[i].v2} = wake(ent_q[i].q2_rdy, ent_q[i].v2, ent_q[i].q2,
          alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result);
      end
    end
  end

  always_comb begin
    disp_ent        = '0;
    disp_ent.busy   = 1'b1;
    disp_ent.openum = disp_openum;
    disp_ent.q1     = disp_Q1;
    disp_ent.q2     = disp_Q2;
    disp_ent.imm    = disp_imm;
    disp_ent.pc     = disp_pc;
    disp_ent.rob_id = disp_rob_id;
    {disp_ent.q1_rdy, disp_ent.v1} = wake(disp_Q1_rdy, disp_V1, disp_Q1,
      alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result);
    {disp_ent.q2_rdy, disp_ent.v2} = wake(disp_Q2_rdy, disp_V2, disp_Q2,
      alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result);
  end

  // Issue picks from stored state and dispatch fills a slot free in stored
  // state, so the two never touch the same entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      ex_openum <= OPENUM_NOP;
      ex_V1     <= ZERO_WORD;
      ex_V2     <= ZERO_WORD;
      ex_imm    <= ZERO_WORD;
      ex_pc     <= ZERO_ADDR;
      ex_rob_id <= '0;
    end else if (rollback) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= FALSE;
      ex_openum <= OPENUM_NOP;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_snp[i];
      if (issue_found) begin
        ex_openum <= ent_q[issue_idx].openum;
        ex_V1     <= ent_q[issue_idx].v1;
        ex_V2     <= ent_q[issue_idx].v2;
        ex_imm    <= ent_q[issue_idx].imm;
        ex_pc     <= ent_q[issue_idx].pc;
        ex_rob_id <= ent_q[issue_idx].rob_id;
        ent_q[issue_idx].busy <= FALSE;
      end else begin
        ex_openum <= OPENUM_NOP;
      end
      if (disp_valid && free_found) ent_q[free_idx] <= disp_ent;
    end
  end

`ifdef RS_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (issue_found && !rollback) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (rs_full && disp_valid)    perf_full_cnt  <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios plus a randomized run
// checked against a behavioural model of the station's entry table.
module tb_rs_station;
  import rs_station_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rollback, disp_valid, disp_Q1_rdy, disp_Q2_rdy;
  logic [OPENUM_LEN-1:0] disp_openum;
  logic [31:0] disp_V1, disp_V2, disp_imm, disp_pc;
  logic [3:0]  disp_Q1, disp_Q2, disp_rob_id;
  logic rs_full;
  logic alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_result, lsb_cdb_result;
  logic [OPENUM_LEN-1:0] ex_openum;
  logic [31:0] ex_V1, ex_V2, ex_imm, ex_pc;
  logic [3:0]  ex_rob_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs_station dut (
    .clk(clk), .rst_n(rst_n), .rollback(rollback),
    .disp_valid(disp_valid), .disp_openum(disp_openum),
    .disp_V1(disp_V1), .disp_V2(disp_V2),
    .disp_Q1_rdy(disp_Q1_rdy), .disp_Q2_rdy(disp_Q2_rdy),
    .disp_Q1(disp_Q1), .disp_Q2(disp_Q2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_id(disp_rob_id),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_result(alu_cdb_result),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_result(lsb_cdb_result),
    .ex_openum(ex_openum), .ex_V1(ex_V1), .ex_V2(ex_V2), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_rob_id(ex_rob_id)
  );

  // Reference model: a table of waiting ops plus the last issued op.
  typedef struct {
    bit busy; bit [5:0] op; bit [31:0] v1, v2, imm, pc;
    bit r1, r2; bit [3:0] q1, q2, rob;
  } ment_t;
  ment_t m [16];
  logic [5:0]  e_op;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [3:0]  e_rob;

  function automatic bit m_full();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic resolve(input bit rdy, input bit [31:0] v, input bit [3:0] q,
                         output bit ordy, output bit [31:0] ov);
    ordy = rdy; ov = v;
    if (!rdy) begin
      if (alu_cdb_valid && alu_cdb_rob_id == q)      begin ordy = 1; ov = alu_cdb_result; end
      else if (lsb_cdb_valid && lsb_cdb_rob_id == q) begin ordy = 1; ov = lsb_cdb_result; end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i].busy = 0;
    e_op = OPENUM_NOP; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
  endtask

  task automatic model_edge();
    int ri, fi; bit full; ment_t n;
    full = m_full();
    if (rollback) begin
      for (int i = 0; i < 16; i++) m[i].busy = 0;
      e_op = OPENUM_NOP;
      return;
    end
    ri = -1; fi = -1;
    for (int i = 15; i >= 0; i--) begin
      if (m[i].busy && m[i].r1 && m[i].r2) ri = i;
      if (!m[i].busy) fi = i;
    end
    if (ri >= 0) begin
      e_op = m[ri].op; e_v1 = m[ri].v1; e_v2 = m[ri].v2;
      e_imm = m[ri].imm; e_pc = m[ri].pc; e_rob = m[ri].rob;
      m[ri].busy = 0;
    end else e_op = OPENUM_NOP;
    for (int i = 0; i < 16; i++) if (m[i].busy) begin
      resolve(m[i].r1, m[i].v1, m[i].q1, m[i].r1, m[i].v1);
      resolve(m[i].r2, m[i].v2, m[i].q2, m[i].r2, m[i].v2);
    end
    if (disp_valid && !full) begin
      n.busy = 1; n.op = disp_openum; n.imm = disp_imm; n.pc = disp_pc; n.rob = disp_rob_id;
      n.q1 = disp_Q1; n.q2 = disp_Q2;
      resolve(disp_Q1_rdy, disp_V1, disp_Q1, n.r1, n.v1);
      resolve(disp_Q2_rdy, disp_V2, disp_Q2, n.r2, n.v2);
      m[fi] = n;
    end
  endtask

  task automatic idle();
    rollback = 0; disp_valid = 0; disp_openum = OPENUM_NOP;
    disp_V1 = 0; disp_V2 = 0; disp_Q1_rdy = 0; disp_Q2_rdy = 0;
    disp_Q1 = 0; disp_Q2 = 0; disp_imm = 0; disp_pc = 0; disp_rob_id = 0;
    alu_cdb_valid = 0; alu_cdb_rob_id = 0; alu_cdb_result = 0;
    lsb_cdb_valid = 0; lsb_cdb_rob_id = 0; lsb_cdb_result = 0;
  endtask

  task automatic disp(input bit [5:0] op, input bit [31:0] v1, input bit r1, input bit [3:0] q1,
                      input bit [31:0] v2, input bit r2, input bit [3:0] q2,
                      input bit [31:0] imm, input bit [31:0] pc, input bit [3:0] rob);
    disp_valid = 1; disp_openum = op; disp_V1 = v1; disp_Q1_rdy = r1; disp_Q1 = q1;
    disp_V2 = v2; disp_Q2_rdy = r2; disp_Q2 = q2; disp_imm = imm; disp_pc = pc; disp_rob_id = rob;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    idle(); rollback = 1; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ex_openum, ex_V1, ex_V2, ex_imm, ex_pc, ex_rob_id, rs_full} !== {OPENUM_NOP, 132'd0, 1'b0}) begin
      bad++; $display("FAIL reset_outputs got op=%0d v1=%h full=%b exp op=0 all-zero full=0", ex_openum, ex_V1, rs_full);
    end
    rst_n = 1;
    tick();
    total++;
    if (ex_openum !== OPENUM_NOP) begin bad++; $display("FAIL reset_idle got=%0d exp=0", ex_openum); end
  endtask

  task automatic test_addi();
    disp(OPENUM_ADDI, 5, 1, 0, 0, 1, 0, 3, 32'h100, 2); tick(); idle();
    total++;
    if (ex_openum !== OPENUM_NOP) begin bad++; $display("FAIL addi_no_same_cycle got=%0d exp=0", ex_openum); end
    tick();
    total++;
    if ({ex_openum, ex_V1, ex_imm, ex_pc, ex_rob_id} !== {OPENUM_ADDI, 32'd5, 32'd3, 32'h100, 4'd2}) begin
      bad++; $display("FAIL addi_issue got op=%0d v1=%0d imm=%0d pc=%h rob=%0d exp op=2 v1=5 imm=3 pc=100 rob=2",
                      ex_openum, ex_V1, ex_imm, ex_pc, ex_rob_id);
    end
    tick();
    total++;
    if (ex_openum !== OPENUM_NOP || ex_V1 !== 32'd5) begin
      bad++; $display("FAIL addi_then_nop got op=%0d v1=%0d exp op=0 v1=5 (held)", ex_openum, ex_V1);
    end
  endtask

  task automatic test_wakeup();
    disp(OPENUM_ADD, 0, 0, 7, 1, 1, 0, 0, 32'h200, 3); tick(); idle();
    tick();
    total++;
    if (ex_openum !== OPENUM_NOP) begin bad++; $display("FAIL wake_wait got=%0d exp=0", ex_openum); end
    alu_cdb_valid = 1; alu_cdb_rob_id = 7; alu_cdb_result = 32'h10; tick(); idle();
    total++;
    if (ex_openum !== OPENUM_NOP) begin bad++; $display("FAIL wake_edge_no_issue got=%0d exp=0", ex_openum); end
    tick();
    total++;
    if ({ex_openum, ex_V1, ex_V2, ex_rob_id} !== {OPENUM_ADD, 32'h10, 32'd1, 4'd3}) begin
      bad++; $display("FAIL wake_issue got op=%0d v1=%h v2=%h rob=%0d exp op=1 v1=10 v2=1 rob=3",
                      ex_openum, ex_V1, ex_V2, ex_rob_id);
    end
  endtask

  task automatic test_bypass();
    disp(OPENUM_SUB, 0, 0, 3, 9, 1, 0, 0, 0, 4);
    lsb_cdb_valid = 1; lsb_cdb_rob_id = 3; lsb_cdb_result = 32'hAB;
    tick(); idle(); tick();
    total++;
    if (ex_openum !== OPENUM_SUB || ex_V1 !== 32'hAB) begin
      bad++; $display("FAIL bypass_lsb got op=%0d v1=%h exp op=3 v1=ab", ex_openum, ex_V1);
    end
    disp(OPENUM_SUB, 0, 0, 3, 9, 1, 0, 0, 0, 4);
    alu_cdb_valid = 1; alu_cdb_rob_id = 3; alu_cdb_result = 1;
    lsb_cdb_valid = 1; lsb_cdb_rob_id = 3; lsb_cdb_result = 2;
    tick(); idle(); tick();
    total++;
    if (ex_openum !== OPENUM_SUB || ex_V1 !== 32'd1) begin
      bad++; $display("FAIL bypass_alu_priority got op=%0d v1=%0d exp op=3 v1=1", ex_openum, ex_V1);
    end
  endtask

  task automatic test_full();
    flush();
    for (int i = 0; i < 16; i++) begin
      disp(OPENUM_ADD, 0, 0, 4'(i), 32'(i), 1, 0, 0, 32'(i), 4'(i)); tick();
    end
    idle();
    total++;
    if (rs_full !== 1'b1) begin bad++; $display("FAIL full_set got=%b exp=1", rs_full); end
    disp(OPENUM_JAL, 32'hDEAD, 1, 0, 0, 1, 0, 0, 0, 4'hE);
    alu_cdb_valid = 1; alu_cdb_rob_id = 5; alu_cdb_result = 32'h77;
    tick();
    alu_cdb_valid = 0;
    total++;
    if (rs_full !== 1'b1 || ex_openum !== OPENUM_NOP) begin
      bad++; $display("FAIL full_wake got full=%b op=%0d exp full=1 op=0", rs_full, ex_openum);
    end
    tick(); idle();
    total++;
    if (rs_full !== 1'b0 || ex_rob_id !== 4'd5 || ex_V1 !== 32'h77) begin
      bad++; $display("FAIL full_issue5 got full=%b rob=%0d v1=%h exp full=0 rob=5 v1=77", rs_full, ex_rob_id, ex_V1);
    end
    disp(OPENUM_ADDI, 32'h55, 1, 0, 0, 1, 0, 1, 0, 5); tick(); idle();
    total++;
    if (rs_full !== 1'b1) begin bad++; $display("FAIL full_refill got=%b exp=1", rs_full); end
    tick();
    total++;
    if (ex_openum !== OPENUM_ADDI || ex_V1 !== 32'h55 || ex_rob_id !== 4'd5) begin
      bad++; $display("FAIL full_new_in_5 got op=%0d v1=%h rob=%0d exp op=2 v1=55 rob=5", ex_openum, ex_V1, ex_rob_id);
    end
    flush();
  endtask

  task automatic test_priority();
    for (int i = 0; i < 10; i++) begin
      disp(OPENUM_ADD, 0, 0, 4'(i), 0, 1, 0, 0, 0, 4'(i)); tick();
    end
    idle();
    alu_cdb_valid = 1; alu_cdb_rob_id = 9; alu_cdb_result = 32'h99;
    lsb_cdb_valid = 1; lsb_cdb_rob_id = 2; lsb_cdb_result = 32'h22;
    tick(); idle(); tick();
    total++;
    if (ex_rob_id !== 4'd2 || ex_V1 !== 32'h22) begin
      bad++; $display("FAIL prio_first got rob=%0d v1=%h exp rob=2 v1=22", ex_rob_id, ex_V1);
    end
    tick();
    total++;
    if (ex_rob_id !== 4'd9 || ex_openum !== OPENUM_ADD) begin
      bad++; $display("FAIL prio_second got rob=%0d op=%0d exp rob=9 op=1", ex_rob_id, ex_openum);
    end
    tick();
    total++;
    if (ex_openum !== OPENUM_NOP) begin bad++; $display("FAIL prio_drain got=%0d exp=0", ex_openum); end
    flush();
  endtask

  task automatic test_rollback();
    disp(OPENUM_ADD, 1, 1, 0, 2, 1, 0, 0, 0, 6); tick();
    disp(OPENUM_BEQ, 3, 1, 0, 4, 1, 0, 0, 0, 7); rollback = 1; tick(); idle();
    total++;
    if (ex_openum !== OPENUM_NOP || rs_full !== 1'b0) begin
      bad++; $display("FAIL rollback_now got op=%0d full=%b exp op=0 full=0", ex_openum, rs_full);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (ex_openum !== OPENUM_NOP) begin bad++; $display("FAIL rollback_quiet cyc=%0d got=%0d exp=0", k, ex_openum); end
    end
  endtask

  task automatic test_random();
    int full_drops = 0;
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(99) < 60)
        disp(6'($urandom_range(5, 1)), $urandom, 1'($urandom_range(1)), 4'($urandom), $urandom,
             1'($urandom_range(1)), 4'($urandom), $urandom, $urandom, 4'($urandom));
      if (disp_valid && rs_full) full_drops++;
      if ($urandom_range(99) < 35) begin alu_cdb_valid = 1; alu_cdb_rob_id = 4'($urandom); alu_cdb_result = $urandom; end
      if ($urandom_range(99) < 35) begin lsb_cdb_valid = 1; lsb_cdb_rob_id = 4'($urandom); lsb_cdb_result = $urandom; end
      rollback = ($urandom_range(99) < 2);
      tick();
      total++;
      if ({ex_openum, ex_V1, ex_V2, ex_imm, ex_pc, ex_rob_id} !== {e_op, e_v1, e_v2, e_imm, e_pc, e_rob}) begin
        bad++; $display("FAIL rand_ex cyc=%0d got=%h exp=%h", c,
          {ex_openum, ex_V1, ex_V2, ex_imm, ex_pc, ex_rob_id}, {e_op, e_v1, e_v2, e_imm, e_pc, e_rob});
      end
      total++;
      if (rs_full !== m_full()) begin bad++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", c, rs_full, m_full()); end
    end
    if (full_drops > 0) $display("note: %0d dispatch requests made while full were dropped", full_drops);
    idle();
  endtask

  task automatic test_async_reset();
    flush();
    for (int i = 0; i < 16; i++) begin
      disp(OPENUM_ADD, 0, 0, 4'(i), 0, 1, 0, 0, 0, 4'(i)); tick();
    end
    idle();
    #2 rst_n = 0; model_reset();
    #1;
    total++;
    if (rs_full !== 1'b0 || ex_openum !== OPENUM_NOP || ex_V1 !== 32'd0) begin
      bad++; $display("FAIL async_reset got full=%b op=%0d v1=%h exp full=0 op=0 v1=0", rs_full, ex_openum, ex_V1);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    alu_cdb_valid = 1; alu_cdb_rob_id = 3; alu_cdb_result = 1; tick(); idle(); tick();
    total++;
    if (ex_openum !== OPENUM_NOP) begin bad++; $display("FAIL async_reset_cleared got=%0d exp=0", ex_openum); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_wakeup();
    test_bypass();
    test_full();
    test_priority();
    test_rollback();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
